// File: rtl/pmem_responder.sv
// pmem_responder: line-granular backing store answering cache pmem requests after a fixed latency
module pmem_responder #(
  parameter int LINES         = 256,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         pmem_error,
  output logic         busy
);
  localparam int AW = LINES > 1 ? $clog2(LINES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        state;
  logic [127:0]  mem [LINES];
  logic [AW-1:0] idx;
  logic [127:0]  wd;
  logic [15:0]   cnt;
  logic          wr, err, a_err, a_lat1, unused_nibble;
  always_comb begin
    a_err         = (pmem_read & pmem_write) | (32'(pmem_address[15:4]) >= LINES);
    a_lat1        = pmem_write ? WRITE_LATENCY == 1 : READ_LATENCY == 1;
    unused_nibble = ^pmem_address[3:0];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pmem_resp  <= 1'b0;
      pmem_error <= 1'b0;
      pmem_rdata <= '0;
      busy       <= 1'b0;
      idx        <= '0;
      wd         <= '0;
      wr         <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
    end else begin
      pmem_resp  <= 1'b0;
      pmem_error <= 1'b0;
      pmem_rdata <= '0;
      case (state)
        IDLE: if (pmem_read | pmem_write) begin
          idx   <= pmem_address[AW+3:4];
          wd    <= pmem_wdata;
          wr    <= pmem_write;
          err   <= a_err;
          cnt   <= pmem_write ? 16'(WRITE_LATENCY - 1) : 16'(READ_LATENCY - 1);
          busy  <= 1'b1;
          state <= a_lat1 ? RESP : WAIT;
          if (a_lat1) begin
            pmem_resp  <= 1'b1;
            pmem_error <= a_err;
            pmem_rdata <= (pmem_write | a_err) ? '0 : mem[pmem_address[AW+3:4]];
          end
        end
        WAIT: begin
          cnt <= cnt - 16'd1;
          if (cnt == 16'd1) begin
            state      <= RESP;
            pmem_resp  <= 1'b1;
            pmem_error <= err;
            pmem_rdata <= (wr | err) ? '0 : mem[idx];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
  // Commit happens only on the edge that ends RESP, so a reset mid-flight drops the write
  always_ff @(posedge clk) begin
    if (state == RESP && wr && !err) mem[idx] <= wd;
  end
endmodule
